pit_sequencer: RTL

- Controller that programs and supervises the mini interval timer (PIT) through its byte-wide write port.
- Accepts a timer request with valid/ready, clears the PIT, then issues the three config writes: config, count high byte, count low byte.
- Counts PIT interrupt pulses and retires the request after a requested number of fires.
- Holds one queued request, so back-to-back jobs chain without returning to software.

---
 rtl/pit_pkg.sv | 38 +++
 rtl/pit_req_shadow.sv | 33 +++
 rtl/pit_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared types and constants for the PIT sequencer and its request shadow.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WR_CFG,
        ST_WR_HI,
        ST_WR_LO,
        ST_ARMED
    } pit_state_t;

    localparam logic [1:0] PIT_ADDR_CFG = 2'b00;
    localparam logic [1:0] PIT_ADDR_HI  = 2'b01;
    localparam logic [1:0] PIT_ADDR_LO  = 2'b10;

    localparam int CFG_DIV_BIT = 7;
    localparam int CFG_REP_BIT = 6;

    typedef struct packed {
        logic        divider;
        logic        rep;
        logic [15:0] count;
    } pit_cfg_t;

    localparam int CFG_W = $bits(pit_cfg_t);

    function automatic logic [7:0] cfg_byte(input pit_cfg_t c);
        logic [7:0] b;
        b              = '0;
        b[CFG_DIV_BIT] = c.divider;
        b[CFG_REP_BIT] = c.rep;
        return b;
    endfunction

endpackage

// File: rtl/pit_req_shadow.sv
// Single-entry holding register for a queued timer request.
// Latency: contents visible the cycle after load.
// Backpressure: owner must not load while vld is set; flush beats load beats pop.
module pit_req_shadow #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         pop,
    input  logic         flush,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (flush)
                vld <= 1'b0;
            else if (load)
                vld <= 1'b1;
            else if (pop)
                vld <= 1'b0;
            if (load)
                dat <= load_dat;
        end
    end

endmodule

// File: rtl/pit_sequencer.sv
// Programs the PIT (clear, cfg, count hi, count lo) and retires a request after N interrupts.
// Latency: first PIT write the cycle after accept; done one cycle after the final interrupt.
// Backpressure: req_ready drops while busy with the shadow full, and whenever cancel is high.
module pit_sequencer
    import pit_pkg::*;
#(
    parameter int FIRE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_divider,
    input  logic              req_repeat,
    input  logic [15:0]       req_count,
    input  logic [FIRE_W-1:0] req_fires,
    input  logic              cancel,
    output logic              pit_reset,
    output logic              pit_we,
    output logic [1:0]        pit_addr,
    output logic [7:0]        pit_data,
    input  logic              pit_irq,
    output logic              busy,
    output logic [FIRE_W-1:0] fire_count,
    output logic              done
);

    localparam int REQ_W = CFG_W + FIRE_W;

    pit_state_t        state, state_n;
    pit_cfg_t          act_cfg, act_cfg_n, req_cfg, shd_cfg;
    logic [FIRE_W-1:0] act_fires, act_fires_n, shd_fires, fire_inc;
    logic [REQ_W-1:0]  shd_dat;
    logic              shd_vld, shd_load, shd_pop, accept, complete;

    logic              pit_reset_n, pit_we_n, busy_n, done_n;
    logic [1:0]        pit_addr_n;
    logic [7:0]        pit_data_n;
    logic [FIRE_W-1:0] fire_count_n;

    assign req_cfg   = '{divider: req_divider, rep: req_repeat, count: req_count};
    assign req_ready = !cancel && (state == ST_IDLE || !shd_vld);
    assign accept    = req_valid && req_ready;
    assign fire_inc  = fire_count + 1'b1;
    assign complete  = (state == ST_ARMED) && pit_irq && !cancel &&
                       (act_fires != '0) && (fire_inc == act_fires);

    // A request that arrives on the completion edge with the shadow empty goes straight to active.
    assign shd_load = accept && (state != ST_IDLE) && !complete;
    assign shd_pop  = complete && shd_vld;
    assign {shd_cfg, shd_fires} = shd_dat;

    pit_req_shadow #(.W(REQ_W)) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .load     (shd_load),
        .load_dat ({req_cfg, req_fires}),
        .pop      (shd_pop),
        .flush    (cancel),
        .vld      (shd_vld),
        .dat      (shd_dat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            act_cfg   <= '0;
            act_fires <= '0;
        end else begin
            state     <= state_n;
            act_cfg   <= act_cfg_n;
            act_fires <= act_fires_n;
        end
    end

    always_comb begin
        state_n     = state;
        act_cfg_n   = act_cfg;
        act_fires_n = act_fires;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n     = ST_WR_CFG;
                    act_cfg_n   = req_cfg;
                    act_fires_n = req_fires;
                end
            end
            ST_CLR:    state_n = ST_WR_CFG;
            ST_WR_CFG: state_n = ST_WR_HI;
            ST_WR_HI:  state_n = ST_WR_LO;
            ST_WR_LO:  state_n = ST_ARMED;
            ST_ARMED: begin
                if (complete) begin
                    if (shd_vld) begin
                        state_n     = ST_CLR;
                        act_cfg_n   = shd_cfg;
                        act_fires_n = shd_fires;
                    end else if (accept) begin
                        state_n     = ST_CLR;
                        act_cfg_n   = req_cfg;
                        act_fires_n = req_fires;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (cancel)
            state_n = ST_IDLE;
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        pit_reset_n = 1'b1;
        pit_we_n    = 1'b0;
        pit_addr_n  = PIT_ADDR_CFG;
        pit_data_n  = 8'h00;
        case (state_n)
            ST_WR_CFG: begin
                pit_reset_n = 1'b0;
                pit_we_n    = 1'b1;
                pit_addr_n  = PIT_ADDR_CFG;
                pit_data_n  = cfg_byte(act_cfg_n);
            end
            ST_WR_HI: begin
                pit_reset_n = 1'b0;
                pit_we_n    = 1'b1;
                pit_addr_n  = PIT_ADDR_HI;
                pit_data_n  = act_cfg_n.count[15:8];
            end
            ST_WR_LO: begin
                pit_reset_n = 1'b0;
                pit_we_n    = 1'b1;
                pit_addr_n  = PIT_ADDR_LO;
                pit_data_n  = act_cfg_n.count[7:0];
            end
            ST_ARMED: pit_reset_n = 1'b0;
            default:  pit_reset_n = 1'b1;
        endcase

        busy_n = (state_n != ST_IDLE);
        done_n = complete;

        fire_count_n = fire_count;
        if (cancel)
            fire_count_n = fire_count;
        else if (state_n == ST_WR_CFG)
            fire_count_n = '0;
        else if (state == ST_ARMED && pit_irq)
            fire_count_n = fire_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pit_reset  <= 1'b1;
            pit_we     <= 1'b0;
            pit_addr   <= PIT_ADDR_CFG;
            pit_data   <= 8'h00;
            busy       <= 1'b0;
            fire_count <= '0;
            done       <= 1'b0;
        end else begin
            pit_reset  <= pit_reset_n;
            pit_we     <= pit_we_n;
            pit_addr   <= pit_addr_n;
            pit_data   <= pit_data_n;
            busy       <= busy_n;
            fire_count <= fire_count_n;
            done       <= done_n;
        end
    end

endmodule
